// File: rtl/redun_to_bin_if.sv
// redun_to_bin_if
//   Bundles the valid/ready handshake of redun_to_bin. The upstream input and
//   the downstream output share one bundle.
//   slave  : converter view (takes i_val/i_dat/i_rdy, drives o_rdy/o_val/o_dat/o_err)
//   master : environment view (drives i_val/i_dat/i_rdy, observes the outputs)
//   Signals:
//     i_val  input transaction valid
//     i_dat  [I_WORD-1:0][COEF_BITS-1:0] redundant-form coefficients
//     o_rdy  converter ready to accept input
//     o_val  result valid
//     o_dat  [O_BITS-1:0] binary result
//     o_err  result not fully reduced / value did not fit, qualified by o_val
//     i_rdy  downstream ready
interface redun_to_bin_if #(
  parameter int unsigned I_WORD    = 5,
  parameter int unsigned COEF_BITS = 9,
  parameter int unsigned O_BITS    = 32
);
  logic                              i_val;
  logic [I_WORD-1:0][COEF_BITS-1:0]  i_dat;
  logic                              o_rdy;
  logic                              o_val;
  logic [O_BITS-1:0]                 o_dat;
  logic                              o_err;
  logic                              i_rdy;

  modport slave (
    input  i_val, i_dat, i_rdy,
    output o_rdy, o_val, o_dat, o_err
  );

  modport master (
    output i_val, i_dat, i_rdy,
    input  o_rdy, o_val, o_dat, o_err
  );
endinterface

// File: rtl/redun_to_bin.sv
// redun_to_bin
//   Converts one poly_mod_mult result from redundant coefficient form into a
//   fully carried binary integer. Carries ripple one word per cycle; with
//   REDUN_TO_BIN_MOD_SUB_EN defined, MODULUS is then subtracted sequentially
//   (at most MAX_SUB times) until the value is below MODULUS. Without the
//   macro the carried value is presented unreduced and o_err flags any bits
//   above the NUM_WORDS*WORD_BITS result width.
//   Ports:
//     i_clk  clock, rising edge
//     i_rst  asynchronous active-high reset
//     bus    redun_to_bin_if.slave: i_val/i_dat/o_rdy input handshake,
//            o_val/o_dat/o_err/i_rdy output handshake
//   One transaction in flight; o_rdy only in IDLE.
module redun_to_bin #(
  parameter int unsigned WORD_BITS       = 8,
  parameter int unsigned NUM_WORDS       = 4,
  parameter logic [WORD_BITS*NUM_WORDS-1:0] MODULUS = 128,
  parameter int unsigned REDUN_WORD_BITS = 1,
  parameter int          MAX_SUB         = 16,
  parameter int unsigned I_WORD          = NUM_WORDS + 1,
  parameter int unsigned COEF_BITS       = WORD_BITS + REDUN_WORD_BITS,
  parameter int unsigned VW              = I_WORD*WORD_BITS + REDUN_WORD_BITS + 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  redun_to_bin_if.slave bus
);

  localparam int unsigned OB  = NUM_WORDS * WORD_BITS;
  localparam int unsigned CRW = COEF_BITS - WORD_BITS + 1;
  localparam int unsigned KW  = (I_WORD > 1) ? $clog2(I_WORD) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(I_WORD - 1);

  if (MODULUS == '0 || MAX_SUB < 0) begin : g_bad_cfg
    $error("redun_to_bin: MODULUS must be nonzero and MAX_SUB non-negative");
  end

`ifdef REDUN_TO_BIN_MOD_SUB_EN
  localparam int unsigned CW = (MAX_SUB > 0) ? $clog2(MAX_SUB + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_SUB);
  localparam logic [VW-1:0] MOD_V   = VW'(MODULUS);

  typedef enum logic [1:0] {ST_IDLE, ST_CARRY, ST_SUB, ST_DONE} state_t;
  logic [CW-1:0] cnt_q;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_CARRY, ST_DONE} state_t;
`endif

  state_t                            state_q;
  logic [I_WORD-1:0][COEF_BITS-1:0]  coef_q;
  logic [VW-1:0]                     v_q;
  logic [CRW-1:0]                    carry_q;
  logic [KW-1:0]                     k_q;
  logic                              val_q;
  logic [OB-1:0]                     dat_q;
  logic                              err_q;

  logic [COEF_BITS:0]                sum;
  logic [CRW-1:0]                    carry_nxt;
  logic [VW-1:0]                     v_carry;

  // V with word k replaced by the current carry step; on the last word the
  // leftover carry also lands in the bits above the top word.
  always_comb begin
    sum       = (COEF_BITS+1)'(coef_q[k_q]) + (COEF_BITS+1)'(carry_q);
    carry_nxt = sum[COEF_BITS:WORD_BITS];
    v_carry   = v_q;
    v_carry[k_q*WORD_BITS +: WORD_BITS] = sum[WORD_BITS-1:0];
    if (k_q == K_LAST) begin
      v_carry[VW-1:I_WORD*WORD_BITS] = carry_nxt;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      coef_q  <= '0;
      v_q     <= '0;
      carry_q <= '0;
      k_q     <= '0;
`ifdef REDUN_TO_BIN_MOD_SUB_EN
      cnt_q   <= '0;
`endif
      val_q   <= 1'b0;
      dat_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.i_val) begin
            coef_q  <= bus.i_dat;
            v_q     <= '0;
            carry_q <= '0;
            k_q     <= '0;
`ifdef REDUN_TO_BIN_MOD_SUB_EN
            cnt_q   <= '0;
`endif
            state_q <= ST_CARRY;
          end
        end
        ST_CARRY: begin
          v_q     <= v_carry;
          carry_q <= carry_nxt;
          k_q     <= k_q + 1'b1;
          if (k_q == K_LAST) begin
`ifdef REDUN_TO_BIN_MOD_SUB_EN
            state_q <= ST_SUB;
`else
            // Result registered straight from the final carry step.
            val_q   <= 1'b1;
            dat_q   <= v_carry[OB-1:0];
            err_q   <= |v_carry[VW-1:OB];
            state_q <= ST_DONE;
`endif
          end
        end
`ifdef REDUN_TO_BIN_MOD_SUB_EN
        ST_SUB: begin
          if (v_q >= MOD_V && cnt_q != CNT_MAX) begin
            v_q   <= v_q - MOD_V;
            cnt_q <= cnt_q + 1'b1;
          end else begin
            val_q   <= 1'b1;
            dat_q   <= v_q[OB-1:0];
            err_q   <= (v_q >= MOD_V);
            state_q <= ST_DONE;
          end
        end
`endif
        ST_DONE: begin
          if (bus.i_rdy) begin
            val_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_rdy = (state_q == ST_IDLE) && !i_rst;
  assign bus.o_val = val_q;
  assign bus.o_dat = dat_q;
  assign bus.o_err = err_q;

endmodule

// File: tb/tb_redun_to_bin.sv
`timescale 1ns/1ps
module tb_redun_to_bin;
  localparam int unsigned WB   = 8;
  localparam int unsigned NW   = 4;
  localparam int unsigned IW   = NW + 1;
  localparam int unsigned CB   = WB + 1;
  localparam int unsigned OB   = NW * WB;
  localparam longint unsigned MOD = 128;
  localparam int MAXS = 16;

  typedef logic [IW-1:0][CB-1:0] coef_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  redun_to_bin_if #(.I_WORD(IW), .COEF_BITS(CB), .O_BITS(OB)) bus ();

  redun_to_bin #(
    .WORD_BITS(WB), .NUM_WORDS(NW), .MODULUS(OB'(MOD)),
    .REDUN_WORD_BITS(1), .MAX_SUB(MAXS)
  ) u_dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the carried value is just the weighted sum of coefficients;
  // reduction is floor division capped at MAXS subtractions.
  function automatic void model(input coef_t d, output longint unsigned dat,
                                output bit err, output int lat);
    longint unsigned v;
    longint unsigned s;
    v = 0;
    for (int k = 0; k < IW; k++) v += 64'(d[k]) << (WB * k);
`ifdef REDUN_TO_BIN_MOD_SUB_EN
    s = v / MOD;
    if (s > 64'(MAXS)) s = 64'(MAXS);
    v   = v - s * MOD;
    err = (v >= MOD);
    dat = v;
    lat = IW + int'(s) + 2;
`else
    s   = 0;
    err = ((v >> OB) != 0);
    dat = v & ((64'd1 << OB) - 1);
    lat = IW + 1 + int'(s);
`endif
  endfunction

  // Monitor / scoreboard: one expectation in flight, checked every cycle.
  typedef enum {M_IDLE, M_WAIT, M_SHOW} mst_t;
  mst_t mst = M_IDLE;
  int edge_cnt = 0;
  int due = 0, acc_cyc = 0, acc_cnt = 0, done_cnt = 0, obs_lat = -1, lat_m = 0;
  longint unsigned exp_dat = 0, last_dat = 0;
  bit exp_err = 0, last_err = 0;
  logic prev_val = 1'b0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_o_val", bus.o_val, 0);
      chk("rst_o_rdy", bus.o_rdy, 0);
      chk("rst_o_dat", bus.o_dat, 0);
      chk("rst_o_err", bus.o_err, 0);
      mst = M_IDLE;
    end else begin
      if (mst == M_WAIT && edge_cnt == due) mst = M_SHOW;
      chk("o_rdy", bus.o_rdy, (mst == M_IDLE));
      chk("o_val", bus.o_val, (mst == M_SHOW));
      if (mst == M_SHOW) begin
        chk("o_dat", bus.o_dat, exp_dat);
        chk("o_err", bus.o_err, exp_err);
      end
      if (bus.o_val && !prev_val) begin
        obs_lat  = edge_cnt - acc_cyc;
        last_dat = bus.o_dat;
        last_err = bus.o_err;
      end
      if (mst == M_SHOW && bus.i_rdy) begin
        mst = M_IDLE;
        done_cnt++;
      end else if (mst == M_IDLE && bus.i_val) begin
        model(bus.i_dat, exp_dat, exp_err, lat_m);
        due     = edge_cnt + lat_m;
        acc_cyc = edge_cnt;
        acc_cnt++;
        mst = M_WAIT;
      end
    end
    prev_val = bus.o_val;
  end

  // Present d until accepted; afterwards i_dat is scrambled (must be ignored).
  task automatic send(input coef_t d, input bit keep);
    int a0;
    int c;
    a0 = acc_cnt;
    c  = 0;
    bus.i_val = 1'b1;
    bus.i_dat = d;
    while (acc_cnt == a0 && c < 60) begin
      @(posedge clk); #1;
      c++;
    end
    chk("accept_seen", (acc_cnt != a0), 1);
    bus.i_val = keep ? 1'b1 : 1'($urandom_range(0, 1));
    bus.i_dat = coef_t'({$urandom, $urandom});
  endtask

  // pol 0: i_rdy high; 1: random i_rdy; 2: i_rdy low for 10 cycles of o_val.
  task automatic finish_txn(input int pol, input bit keep);
    int d0;
    int c;
    int shown;
    d0 = done_cnt;
    c = 0;
    shown = 0;
    while (done_cnt == d0 && c < 100) begin
      if (pol == 0) bus.i_rdy = 1'b1;
      else if (pol == 1) bus.i_rdy = 1'($urandom_range(0, 1));
      else begin
        if (bus.o_val) shown++;
        bus.i_rdy = (shown > 10);
      end
      @(posedge clk); #1;
      c++;
    end
    chk("done_seen", (done_cnt != d0), 1);
    bus.i_rdy = 1'b0;
    bus.i_val = keep;
  endtask

  task automatic pin(input string tag, input int lat, input longint unsigned dat, input bit err);
    chk({tag, "_lat"}, longint'(obs_lat), longint'(lat));
    chk({tag, "_dat"}, last_dat, dat);
    chk({tag, "_err"}, last_err, err);
  endtask

  initial begin
    coef_t z, s2, s3, w4, d;
    longint unsigned md;
    bit me;
    int ml;
    int rel;
    z  = '0;
    s2 = '0; s2[0] = 9'h1FF;
    s3 = '0; s3[1] = 9'h010;
    w4 = '0; w4[4] = 9'h001;

    bus.i_val = 1'b0;
    bus.i_dat = '0;
    bus.i_rdy = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_async_rdy", bus.o_rdy, 0);
    bus.i_val = 1'b1;
    bus.i_dat = z;
    @(posedge clk); #1;
    rst = 1'b0;
    rel = edge_cnt;

    // All-zero, with i_val already high at reset release
    send(z, 0);
    chk("first_accept_edge", longint'(acc_cyc - rel), 0);
    finish_txn(0, 0);
`ifdef REDUN_TO_BIN_MOD_SUB_EN
    pin("zero", 7, 64'h0, 0);
`else
    pin("zero", 6, 64'h0, 0);
`endif

    // Model pin on scenario 2
    model(s2, md, me, ml);
`ifdef REDUN_TO_BIN_MOD_SUB_EN
    chk("model_s2_dat", md, 64'h7F);
    chk("model_s2_lat", longint'(ml), 10);
`else
    chk("model_s2_dat", md, 64'h1FF);
    chk("model_s2_lat", longint'(ml), 6);
`endif

    send(s2, 0);
    finish_txn(0, 0);
`ifdef REDUN_TO_BIN_MOD_SUB_EN
    pin("s2", 10, 64'h7F, 0);
`else
    pin("s2", 6, 64'h1FF, 0);
`endif

    send(s3, 0);
    finish_txn(1, 0);
`ifdef REDUN_TO_BIN_MOD_SUB_EN
    pin("s3", 5 + 16 + 2, 64'h800, 1);
`else
    pin("s3", 6, 64'h1000, 0);
`endif

    send(w4, 0);
    finish_txn(0, 0);
`ifdef REDUN_TO_BIN_MOD_SUB_EN
    pin("w4", 23, 64'hFFFFF800, 1);
`else
    pin("w4", 6, 64'h0, 1);
`endif

    // Backpressure with i_val held high, then back-to-back transaction
    send(s2, 1);
    finish_txn(2, 1);
    send(s2, 0);
    finish_txn(0, 0);
`ifdef REDUN_TO_BIN_MOD_SUB_EN
    pin("bp_next", 10, 64'h7F, 0);
`else
    pin("bp_next", 6, 64'h1FF, 0);
`endif

    // Reset pulse mid-CARRY
    send(s2, 0);
    bus.i_val = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_o_rdy", bus.o_rdy, 0);
    chk("midrst_o_val", bus.o_val, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    send(s2, 0);
    finish_txn(0, 0);
`ifdef REDUN_TO_BIN_MOD_SUB_EN
    pin("after_rst", 10, 64'h7F, 0);
`else
    pin("after_rst", 6, 64'h1FF, 0);
`endif

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        d = coef_t'({$urandom, $urandom});
      end else begin
        d = '0;
        d[0] = 9'($urandom_range(0, 511));
        d[1] = 9'($urandom_range(0, 7));
      end
      send(d, 0);
      finish_txn(int'($urandom_range(0, 1)), 0);
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
